pll_lock_supervisor: RTL

//  Consumer side of the rPLL LOCK output: runs in the PLL output clock domain, synchronises the

---
 rtl/pll_lock_supervisor_if.sv | 30 +++
 rtl/pll_lock_supervisor.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the core it resets.
// The master side is the supervisor; the slave side supplies lock and consumes the resets.
interface pll_lock_supervisor_if #(
    parameter int CNT_W = 8
);
    logic             lock;
    logic             sys_reset_n;
    logic             ready;
    logic             ce;
    logic             loss_pulse;
    logic [CNT_W-1:0] loss_count;

    modport master (
        input  lock,
        output sys_reset_n,
        output ready,
        output ce,
        output loss_pulse,
        output loss_count
    );

    modport slave (
        output lock,
        input  sys_reset_n,
        input  ready,
        input  ce,
        input  loss_pulse,
        input  loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Qualifies the asynchronous PLL lock flag, generates the core reset and clock-enable strobe,
// and counts lock-loss events in the PLL output clock domain.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4096,
    parameter int HOLD_CYCLES   = 256,
    parameter int CE_DIV        = 5,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset_n,
    pll_lock_supervisor_if.master bus
);
    localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int DW      = $clog2(CE_DIV);

    localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0]    CE_LAST     = DW'(CE_DIV - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                lock_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [DW-1:0]       div_r, div_s;
    logic                ce_r, ce_s;
    logic                loss_pulse_r, loss_pulse_s;
    logic [CNT_W-1:0]    loss_count_r, loss_count_s;
    logic                run_r, run_s;

    assign lock_s = sync_r[SYNC_STAGES-1];

    // Lock synchroniser: shift the asynchronous flag through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.lock};
        end
    end

    // Next-state, shared counter, divider and output decode.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        div_s        = div_r;
        ce_s         = 1'b0;
        loss_pulse_s = 1'b0;
        loss_count_s = loss_count_r;
        case (state_r)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_s = STABILIZE;
                    cnt_s   = '0;
                end else begin
                    state_s = WAIT_LOCK;
                end
            end
            STABILIZE: begin
                // A dropout here is a glitch, not a loss: restart qualification silently.
                if (!lock_s) begin
                    state_s = WAIT_LOCK;
                end else if (cnt_r == STABLE_LAST) begin
                    state_s = RUN;
                    div_s   = '0;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_s      = HOLD;
                    cnt_s        = '0;
                    loss_pulse_s = 1'b1;
                    if (loss_count_r != COUNT_MAX) begin
                        loss_count_s = loss_count_r + CNT_W'(1);
                    end else begin
                        loss_count_s = loss_count_r;
                    end
                end else if (div_r == CE_LAST) begin
                    div_s = '0;
                    ce_s  = 1'b1;
                end else begin
                    div_s = div_r + DW'(1);
                end
            end
            HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    state_s = WAIT_LOCK;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = WAIT_LOCK;
                cnt_s   = '0;
                div_s   = '0;
            end
        endcase
        run_s = (state_s == RUN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= WAIT_LOCK;
            cnt_r        <= '0;
            div_r        <= '0;
            ce_r         <= 1'b0;
            loss_pulse_r <= 1'b0;
            loss_count_r <= '0;
            run_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            div_r        <= div_s;
            ce_r         <= ce_s;
            loss_pulse_r <= loss_pulse_s;
            loss_count_r <= loss_count_s;
            run_r        <= run_s;
        end
    end

    assign bus.sys_reset_n = run_r;
    assign bus.ready       = run_r;
    assign bus.ce          = ce_r;
    assign bus.loss_pulse  = loss_pulse_r;
    assign bus.loss_count  = loss_count_r;
endmodule
